icosoc_evdelta: RTL and testbench
=================================

# icosoc_evdelta

Downstream consumer of the trigger recorder's event FIFO. It runs in the system clock domain on the read side of the crossclk FIFO. Each 64-bit event {io[15:0], marker, timestamp[46:0]} is turned into compact 32-bit delta-time records and buffered in an internal FIFO that the CPU drains over the standard icosoc ctrl bus. This cuts CPU read traffic from two bus words per event to one in the common case.

## Interface
Parameters:
- DEPTH, 256, output record FIFO depth in 32-bit words (power of two, ≥4)
- CW, $clog2(DEPTH)+1, fill-count width (derived, not overridden)

Ports:
- clk  in  1  system clock; the only clock
- resetn  in  1  synchronous, active-low reset
- in_nempty  in  1  event FIFO not empty; in_data valid when high
- in_data  in  64  head event: [63:48] io, [47] marker (ignored), [46:0] timestamp
- in_pop  out  1  one-cycle pulse, consumes head event
- ctrl_wr  in  4  bus write strobes (any bit set = write)
- ctrl_rd  in  1  bus read
- ctrl_addr  in  16  bus address
- ctrl_wdat  in  32  bus write data
- ctrl_rdat  out  32  bus read data, valid only while ctrl_done is high
- ctrl_done  out  1  one-cycle bus completion pulse

## Operation
- Record format, bit 31 = tag:
  - EVT: {1'b0, io[15:0], delta[14:0]}
  - OVF: {1'b1, hi[30:0]}, hi = min(delta >> 15, 0x7FFF_FFFF)
- delta = (timestamp − prev_ts) mod 2^47. prev_ts is updated to timestamp on each consumed event and is 0 after reset or clear.
- The FSM emits OVF then EVT when delta ≥ 2^15; otherwise it emits EVT only. Decoder rule: total delta = hi·2^15 + low.
- FSM states:
  - IDLE: go to CALC when in_nempty and free ≥ 2 (free = DEPTH − fill). The room check is always 2 words, even for small deltas.
  - CALC: register io and delta. Go to OVF if delta[46:15] ≠ 0, else go to EVT.
  - OVF: push OVF record, go to EVT.
  - EVT: push EVT record, pulse in_pop, update prev_ts, go to WAIT.
  - WAIT: one cycle so the FIFO head can update, then go to IDLE.
- Bus map (address decode is exact):
  - 0x0 read: {fill[CW−1:0] zero-extended into [31:16], 15'b0, nempty}. Writes are acknowledged and ignored.
  - 0x4 read: head record, then pop. Reading when empty returns 0 with no pop. Writes are acknowledged and ignored.
  - 0x8 write: bit0 = 1 triggers clear (flush record FIFO, prev_ts := 0, FSM := IDLE). Read returns 0.
  - Other addresses: read returns 0, writes have no effect. Every access gets ctrl_done.
- A simultaneous bus pop and FSM push are both performed, so fill is unchanged.
- Clear has priority over any FSM push in the same cycle; that push is discarded. If clear lands in CALC or OVF, the in-progress event is not popped and is reprocessed from IDLE against prev_ts = 0. If clear lands in EVT, the in_pop still fires but the EVT record is discarded.
- Reset mid-operation: same effect as clear, plus all bus outputs go to 0.

## Timing
- Reset values: in_pop = 0, ctrl_done = 0, ctrl_rdat = 0, FSM = IDLE, fill = 0, prev_ts = 0.
- Bus: a request seen with ctrl_done = 0 produces ctrl_done = 1 on the next cycle. The request is held by the master until done. The cycle in which ctrl_done is high ignores requests.
- Read data on 0x4 is the head at the request cycle. The pop takes effect in the ctrl_done cycle.
- Event throughput: 4 cycles per EVT-only event (IDLE→CALC→EVT→WAIT) and 5 with OVF.
- in_pop is high in the EVT cycle only. A record pushed in cycle n is visible in fill at cycle n+1.
- Latency from in_nempty rising in IDLE to the EVT record becoming readable: 3 cycles (4 with OVF).

## Test plan
- Event io=0x0001, ts=100 after reset → exactly one record 0x0000_8064; in_pop pulses once.
- Follow-up io=0x0003, ts=40000 → records 0x8000_0001, then 0x0001_9BDC.
- Wrap: prev ts = 2^47−10, next io=0, ts=5 → single record 0x0000_000F.
- Saturation: from prev_ts = 0, ts = 2^47−1, io = 0 → records 0xFFFF_FFFF, then 0x0000_7FFF.
- Full: DEPTH=256, 300 queued small-delta events, no reads → fill = 255, in_pop count = 255. One 0x4 read → fill = 254, then one more event is consumed and fill = 255.
- Clear during CALC of a pending ts=50 event (prev_ts = 20) → fill = 0, no in_pop for that event. It is then reprocessed as record delta = 50 (low bits 0x32).

Source files
------------

// File: rtl/icosoc_evdelta.sv
// Converts 64-bit timestamped events into compact 32-bit delta-time records.
// Records are buffered in a local FIFO that the CPU drains over the ctrl bus.
module icosoc_evdelta #(
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_nempty,
  input  logic [63:0] in_data,
  output logic        in_pop,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done
);
  // state | meaning
  // IDLE  | wait for an event and room for two records
  // CALC  | latch io, timestamp and delta against prev_ts
  // OVF   | push overflow record carrying delta >> 15
  // EVT   | push event record, pop the event, advance prev_ts
  // WAIT  | let the event FIFO head update
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_OVF, S_EVT, S_WAIT} state_t;

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FILL_LIM = CW'(DEPTH - 1);

  state_t        state;
  logic [46:0]   prev_ts;
  logic [46:0]   ts_reg;
  logic [46:0]   delta;
  logic [46:0]   delta_c;
  logic [15:0]   io_reg;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] fill;
  logic          nempty;
  logic          req;
  logic          is_wr;
  logic          clear;
  logic          bus_pop;
  logic          push;
  logic [31:0]   push_data;
  logic [31:0]   bus_rdat;
  logic          unused_bits;

  assign unused_bits = ^{in_data[47], ctrl_wdat[31:1]};

  assign nempty  = (fill != '0);
  assign delta_c = in_data[46:0] - prev_ts;
  assign req     = (|ctrl_wr || ctrl_rd) && !ctrl_done;
  assign is_wr   = |ctrl_wr;
  assign clear   = req && is_wr && (ctrl_addr == 16'h0008) && ctrl_wdat[0];
  assign bus_pop = req && !is_wr && ctrl_rd && (ctrl_addr == 16'h0004) && nempty;

  // Clear wins over a push landing in the same cycle.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (state == S_OVF) begin
      push      = 1'b1;
      push_data = {1'b1, delta[46] ? 31'h7FFF_FFFF : delta[45:15]};
    end else if (state == S_EVT) begin
      push      = 1'b1;
      push_data = {1'b0, io_reg, delta[14:0]};
    end
    if (clear) push = 1'b0;
  end

  always_comb begin
    bus_rdat = '0;
    if (!is_wr && ctrl_rd) begin
      case (ctrl_addr)
        16'h0000: bus_rdat = {{(16-CW){1'b0}}, fill, 15'b0, nempty};
        16'h0004: bus_rdat = nempty ? mem[rptr] : '0;
        default:  bus_rdat = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      prev_ts   <= '0;
      ts_reg    <= '0;
      delta     <= '0;
      io_reg    <= '0;
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      in_pop    <= 1'b0;
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= req;
      ctrl_rdat <= req ? bus_rdat : '0;
      in_pop    <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        prev_ts <= '0;
        wptr    <= '0;
        rptr    <= '0;
        fill    <= '0;
      end else begin
        if (push)    wptr <= wptr + AW'(1);
        if (bus_pop) rptr <= rptr + AW'(1);
        case ({push, bus_pop})
          2'b10:   fill <= fill + CW'(1);
          2'b01:   fill <= fill - CW'(1);
          default: fill <= fill;
        endcase
        case (state)
          S_IDLE: if (in_nempty && (fill < FILL_LIM)) state <= S_CALC;
          S_CALC: begin
            io_reg <= in_data[63:48];
            ts_reg <= in_data[46:0];
            delta  <= delta_c;
            if (delta_c[46:15] != '0) begin
              state <= S_OVF;
            end else begin
              state  <= S_EVT;
              in_pop <= 1'b1;
            end
          end
          S_OVF: begin
            state  <= S_EVT;
            in_pop <= 1'b1;
          end
          S_EVT: begin
            prev_ts <= ts_reg;
            state   <= S_WAIT;
          end
          S_WAIT:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_icosoc_evdelta.sv
// Bench for icosoc_evdelta: upstream event FIFO model, bus master tasks and an
// arithmetic record model that predicts every record the CPU should read.
module tb_icosoc_evdelta;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_nempty = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_pop;
  logic [3:0]  ctrl_wr = '0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  int n_assert = 0;
  int n_fail = 0;
  int unsigned pop_cnt = 0;
  logic [63:0] evq[$];
  logic [31:0] expq[$];
  longint unsigned m_prev = 0;
  localparam longint unsigned P47 = 64'h0000_8000_0000_0000;
  localparam longint unsigned M47 = 64'h0000_7FFF_FFFF_FFFF;

  always #5 clk = ~clk;

  icosoc_evdelta dut (
    .clk(clk), .resetn(resetn), .in_nempty(in_nempty), .in_data(in_data),
    .in_pop(in_pop), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done)
  );

  // Expected records from the decoder rule: delta = hi*2^15 + low, hi saturated.
  function automatic void model_consume(input logic [63:0] ev);
    longint unsigned ts, dl, hi;
    ts = 64'(ev[46:0]);
    dl = (ts + P47 - m_prev) % P47;
    if (dl >= 32768) begin
      hi = dl / 32768;
      if (hi > 64'h7FFF_FFFF) hi = 64'h7FFF_FFFF;
      expq.push_back(32'(64'h8000_0000 + hi));
    end
    expq.push_back(32'(64'(ev[63:48]) * 32768 + dl % 32768));
    m_prev = ts;
  endfunction

  always @(negedge clk) begin
    if (in_pop) begin
      pop_cnt++;
      if (evq.size() > 0) begin
        model_consume(evq[0]);
        void'(evq.pop_front());
      end
    end
    in_nempty = (evq.size() > 0);
    in_data   = (evq.size() > 0) ? evq[0] : 64'h0;
  end

  function automatic logic [63:0] mkev(input logic [15:0] io, input logic mk,
                                       input longint unsigned ts);
    logic [46:0] t;
    t = 47'(ts & M47);
    return {io, mk, t};
  endfunction

  function automatic logic [31:0] st_exp(input int f);
    return (32'(f) << 16) | 32'(f != 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_acc(input logic [3:0] wr, input logic rd, input logic [15:0] a,
                         input logic [31:0] wd, output logic [31:0] rdat);
    int n = 0;
    ctrl_wr = wr; ctrl_rd = rd; ctrl_addr = a; ctrl_wdat = wd;
    do begin @(posedge clk); #1; n++; end while (!ctrl_done && n < 8);
    if (n != 1) chk("bus_latency", 64'(n), 64'd1);
    rdat = ctrl_rdat;
    ctrl_wr = '0; ctrl_rd = 1'b0;
    tick(1);
  endtask

  task automatic rd32(input logic [15:0] a, output logic [31:0] d);
    bus_acc(4'b0000, 1'b1, a, 32'h0, d);
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] d;
    bus_acc(4'b1111, 1'b0, a, wd, d);
    chk("wr_rdat_zero", d, 0);
  endtask

  task automatic do_clear();
    wr32(16'h0008, 32'h1);
    expq.delete();
    m_prev = 0;
  endtask

  task automatic chk_status(input string tag, input int f);
    logic [31:0] d;
    rd32(16'h0000, d);
    chk(tag, d, st_exp(f));
  endtask

  task automatic pop_exp();
    if (expq.size() > 0) void'(expq.pop_front());
  endtask

  task automatic rd_rec_model(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (expq.size() > 0) ? expq[0] : 32'hDEAD_BEEF;
    rd32(16'h0004, d);
    chk(tag, d, e);
    pop_exp();
  endtask

  task automatic wait_pops(input int unsigned target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    chk("pop_count", 64'(pop_cnt), 64'(target));
    tick(4);
  endtask

  task automatic drain_all();
    logic [31:0] d;
    int f;
    for (int it = 0; it < 20; it++) begin
      if (evq.size() == 0 && expq.size() == 0) break;
      rd32(16'h0000, d);
      f = int'(d[31:16]);
      for (int k = 0; k < f; k++) rd_rec_model("drain_rec");
      if (f == 0) tick(4);
    end
    chk("drain_model_empty", 64'(expq.size()), 64'd0);
    chk_status("drain_fill", 0);
  endtask

  initial begin
    logic [31:0] d;
    int unsigned p0;
    longint unsigned ts;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_in_pop", in_pop, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_rdat", ctrl_rdat, 0);
    resetn = 1'b1;
    tick(2);
    chk_status("rst_fill", 0);

    evq.push_back(mkev(16'h0001, 1'b0, 100));
    wait_pops(1, 50);
    chk_status("one_fill", 1);
    rd32(16'h0004, d); chk("rec_8064", d, 32'h0000_8064); pop_exp();

    evq.push_back(mkev(16'h0003, 1'b1, 40000));
    wait_pops(2, 50);
    chk_status("ovf_fill", 2);
    rd32(16'h0004, d); chk("rec_ovf_hi", d, 32'h8000_0001); pop_exp();
    rd32(16'h0004, d); chk("rec_ovf_evt", d, 32'h0001_9BDC); pop_exp();
    rd32(16'h0004, d); chk("empty_read", d, 0);
    chk_status("empty_fill", 0);

    evq.push_back(mkev(16'h0000, 1'b0, P47 - 10));
    evq.push_back(mkev(16'h0000, 1'b0, 5));
    wait_pops(4, 60);
    chk_status("wrap_fill", 3);
    rd_rec_model("wrap_pre0");
    rd_rec_model("wrap_pre1");
    rd32(16'h0004, d); chk("wrap_rec", d, 32'h0000_000F); pop_exp();

    do_clear();
    evq.push_back(mkev(16'h0000, 1'b0, P47 - 1));
    wait_pops(5, 50);
    rd32(16'h0004, d); chk("sat_hi", d, 32'hFFFF_FFFF); pop_exp();
    rd32(16'h0004, d); chk("sat_low", d, 32'h0000_7FFF); pop_exp();

    evq.push_back(mkev(16'h00AA, 1'b0, 20));
    wait_pops(6, 50);
    rd_rec_model("pre_clear_rec");
    p0 = pop_cnt;
    evq.push_back(mkev(16'h0055, 1'b0, 50));
    tick(1);
    do_clear();
    chk("clr_no_pop", 64'(pop_cnt), 64'(p0));
    chk_status("clr_fill", 0);
    wait_pops(p0 + 1, 50);
    rd32(16'h0004, d); chk("clr_reproc", d, {1'b0, 16'h0055, 15'h0032}); pop_exp();

    evq.push_back(mkev(16'h1234, 1'b1, 77));
    wait_pops(p0 + 2, 50);
    wr32(16'h0008, 32'h0000_0002);
    chk_status("noclr_fill", 1);
    rd32(16'h0008, d); chk("rd_addr8", d, 0);
    rd32(16'h000C, d); chk("rd_addrC", d, 0);
    rd32(16'h0104, d); chk("rd_alias104", d, 0);
    wr32(16'h0004, 32'hFFFF_FFFF);
    wr32(16'h0000, 32'hFFFF_FFFF);
    chk_status("wr_ignored_fill", 1);
    rd_rec_model("decode_rec");
    chk_status("decode_empty", 0);

    ts = m_prev;
    p0 = pop_cnt;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) ts = (ts + 64'($urandom_range(0, 70000))) & M47;
      else ts = {32'($urandom), 32'($urandom)} & M47;
      evq.push_back(mkev(16'($urandom), 1'($urandom), ts));
    end
    wait_pops(p0 + 40, 400);
    drain_all();

    do_clear();
    p0 = pop_cnt;
    ts = 0;
    for (int i = 0; i < 300; i++) begin
      ts = ts + 64'($urandom_range(1, 1000));
      evq.push_back(mkev(16'($urandom), 1'b0, ts));
    end
    wait_pops(p0 + 255, 2000);
    tick(30);
    chk("full_pops", 64'(pop_cnt), 64'(p0 + 255));
    chk_status("full_fill", 255);
    rd_rec_model("full_head");
    chk_status("full_after_read", 254);
    tick(20);
    chk("full_pops2", 64'(pop_cnt), 64'(p0 + 256));
    chk_status("full_refill", 255);
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
